puf_eval_ctrl: RTL

Parametrised evaluation controller for an array of N_CHAIN arbiter PUF delay chains of C_LENGTH stages each. Per accepted challenge it drives the chains' launch pulse N_VOTE times, synchronises and counts each chain's arbiter output, and returns a per-chain majority-voted response over a valid/ready handshake. It sits between the tile's I/O wrapper and the arbiter chain array, which remains a separate hard block.

---
 rtl/puf_eval_ctrl_if.sv | 23 ++
 rtl/puf_eval_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl_if.sv
// Request/response handshake bundle between the tile I/O wrapper and puf_eval_ctrl.
interface puf_eval_ctrl_if #(
  parameter int N_CHAIN  = 8,
  parameter int C_LENGTH = 8
);
  logic                req_valid;
  logic                req_ready;
  logic [C_LENGTH-1:0] req_chal;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [N_CHAIN-1:0]  rsp_data;
  logic [N_CHAIN-1:0]  rsp_stable;

  modport master (
    output req_valid, req_chal, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_stable
  );

  modport slave (
    input  req_valid, req_chal, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_stable
  );
endinterface

// File: rtl/puf_eval_ctrl.sv
// Arbiter PUF evaluation controller: N_VOTE launches per challenge, per-chain majority vote.
// Optional per-chain unanimity tracking is built when PUF_STABILITY_EN is defined.
module puf_eval_ctrl #(
  parameter int N_CHAIN    = 8,
  parameter int C_LENGTH   = 8,
  parameter int N_VOTE     = 5,
  parameter int SETTLE_CYC = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  puf_eval_ctrl_if.slave                bus,
  output logic                          puf_pulse,
  output logic [N_CHAIN*C_LENGTH-1:0]   puf_chal,
  input  logic [N_CHAIN-1:0]            puf_q
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_FIRE = 3'd2;
  localparam logic [2:0] S_SYNC = 3'd3;
  localparam logic [2:0] S_ACC  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int VW = $clog2(N_VOTE + 1);
  localparam int TW = $clog2(SETTLE_CYC + 2);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] SYNC_LD   = TW'(1);
  localparam logic [VW-1:0] LAST_RND  = VW'(N_VOTE - 1);
  localparam logic [VW-1:0] HALF      = VW'(N_VOTE / 2);

  logic [2:0]                  state_q, state_d;
  logic [TW-1:0]               tmr_q, tmr_d;
  logic [VW-1:0]               rnd_q, rnd_d;
  logic [VW-1:0]               cnt_q [N_CHAIN];
  logic [VW-1:0]               cnt_d [N_CHAIN];
  logic [N_CHAIN-1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic                        pulse_q, pulse_d;
  logic [N_CHAIN*C_LENGTH-1:0] chal_q, chal_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [N_CHAIN-1:0]          rsp_data_q, rsp_data_d;
  logic [N_CHAIN-1:0]          rsp_stable_q, rsp_stable_d;
`ifdef PUF_STABILITY_EN
  logic [N_CHAIN-1:0]          flag_q, flag_d, ref_q, ref_d;
`endif

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    rnd_d        = rnd_q;
    cnt_d        = cnt_q;
    pulse_d      = pulse_q;
    chal_d       = chal_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_stable_d = rsp_stable_q;
    sync1_d      = puf_q;
    sync2_d      = sync1_q;
`ifdef PUF_STABILITY_EN
    flag_d       = flag_q;
    ref_d        = ref_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          // chain i sees the base challenge rotated left by i (mod C_LENGTH)
          for (int i = 0; i < N_CHAIN; i++) begin
            for (int j = 0; j < C_LENGTH; j++) begin
              chal_d[i*C_LENGTH + ((i + j) % C_LENGTH)] = bus.req_chal[j];
            end
          end
          for (int i = 0; i < N_CHAIN; i++) cnt_d[i] = '0;
          rnd_d   = '0;
          tmr_d   = SETTLE_LD;
          pulse_d = 1'b0;
          state_d = S_ARM;
`ifdef PUF_STABILITY_EN
          flag_d  = '0;
`endif
        end
      end
      S_ARM: begin
        if (tmr_q == '0) begin
          tmr_d   = SETTLE_LD;
          pulse_d = 1'b1;
          state_d = S_FIRE;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_FIRE: begin
        if (tmr_q == '0) begin
          tmr_d   = SYNC_LD;
          state_d = S_SYNC;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_SYNC: begin
        if (tmr_q == '0) state_d = S_ACC;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_ACC: begin
        for (int i = 0; i < N_CHAIN; i++) begin
          if (sync2_q[i]) cnt_d[i] = cnt_q[i] + VW'(1);
        end
`ifdef PUF_STABILITY_EN
        if (rnd_q == '0) ref_d  = sync2_q;
        else             flag_d = flag_q | (sync2_q ^ ref_q);
`endif
        rnd_d = rnd_q + VW'(1);
        if (rnd_q == LAST_RND) begin
          state_d = S_DONE;
        end else begin
          tmr_d   = SETTLE_LD;
          pulse_d = 1'b0;
          state_d = S_ARM;
        end
      end
      S_DONE: begin
        // first DONE cycle registers the vote; later cycles wait for the consumer
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          for (int i = 0; i < N_CHAIN; i++) rsp_data_d[i] = (cnt_q[i] > HALF);
`ifdef PUF_STABILITY_EN
          rsp_stable_d = ~flag_q;
`else
          rsp_stable_d = '1;
`endif
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      rnd_q        <= '0;
      for (int i = 0; i < N_CHAIN; i++) cnt_q[i] <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      pulse_q      <= 1'b0;
      chal_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_stable_q <= '0;
`ifdef PUF_STABILITY_EN
      flag_q       <= '0;
      ref_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      rnd_q        <= rnd_d;
      cnt_q        <= cnt_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      pulse_q      <= pulse_d;
      chal_q       <= chal_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_stable_q <= rsp_stable_d;
`ifdef PUF_STABILITY_EN
      flag_q       <= flag_d;
      ref_q        <= ref_d;
`endif
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_stable = rsp_stable_q;
  assign puf_pulse      = pulse_q;
  assign puf_chal       = chal_q;

endmodule
